// File: rtl/sram_1rw1r_param.sv
// Two-port SRAM model: port 0 read/write with byte mask, port 1 read-only,
// two-stage request pipeline, and a full-array clear sweep.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   csb0, web0, wmask0    - port-0 chip select (low), write enable (low), byte mask
//   addr0, din0, dout0    - port-0 address, write data, registered read data
//   csb1, addr1, dout1    - port-1 chip select (low), address, registered read data
//   clr_req               - one-cycle pulse requesting a full-array clear
//   busy                  - high while the clear sweep runs
module sram_1rw1r_param #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH,
   localparam int unsigned WMASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   input  logic                   clr_req,
   output logic                   busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

   logic                   csb0_r, web0_r, csb1_r;
   logic [WMASK_WIDTH-1:0] wmask0_r;
   logic [ADDR_WIDTH-1:0]  addr0_r, addr1_r;
   logic [DATA_WIDTH-1:0]  din0_r;

   logic                  access_en, in0, in1, wr0, rd0, rd1, fwd;
   logic [DATA_WIDTH-1:0] rd0_word, rd1_word;

   // Stage 1: capture requests; anything arriving while busy is squashed to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         csb0_r   <= 1'b1;
         web0_r   <= 1'b0;
         wmask0_r <= '0;
         addr0_r  <= '0;
         din0_r   <= '0;
         csb1_r   <= 1'b1;
         addr1_r  <= '0;
      end else begin
         csb0_r   <= csb0 | busy;
         web0_r   <= web0;
         wmask0_r <= wmask0;
         addr0_r  <= addr0;
         din0_r   <= din0;
         csb1_r   <= csb1 | busy;
         addr1_r  <= addr1;
      end
   end

   // Stage 2 decode; a clear entering on this edge wins over the access
   always_comb begin
      access_en = (state == IDLE) && !clr_req;
      in0       = 32'(addr0_r) < RAM_DEPTH;
      in1       = 32'(addr1_r) < RAM_DEPTH;
      wr0       = access_en && !csb0_r && !web0_r && in0;
      rd0       = access_en && !csb0_r && web0_r;
      rd1       = access_en && !csb1_r;
      fwd       = wr0 && (addr1_r == addr0_r);
      rd0_word  = in0 ? mem[addr0_r] : '0;
      rd1_word  = in1 ? mem[addr1_r] : '0;
      // Write-through: masked bytes of the concurrent port-0 write replace the old word
      for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
         if (fwd && wmask0_r[i]) rd1_word[i*8 +: 8] = din0_r[i*8 +: 8];
      end
   end

   // Clear FSM next-state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            if (cnt == LAST_ADDR) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ADDR_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clear FSM state register; reset starts a sweep from address 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt == CLEAR);
      end
   end

   // Array update: clear sweep or masked port-0 write, never during reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[cnt] <= '0;
         end else if (wr0) begin
            for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
               if (wmask0_r[i]) mem[addr0_r][i*8 +: 8] <= din0_r[i*8 +: 8];
            end
         end
      end
   end

   // Read data registers hold unless a read is performed
   always_ff @(posedge clk) begin
      if (rst) begin
         dout0 <= '0;
         dout1 <= '0;
      end else begin
         if (rd0) dout0 <= rd0_word;
         if (rd1) dout1 <= rd1_word;
      end
   end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width in bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 2**ADDR_WIDTH, number of words; legal range is 2 to 2**ADDR_WIDTH.
REQ-004 SHALL derive localparam WMASK_WIDTH = DATA_WIDTH/8, one mask bit per byte.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port csb0, input, 1, port-0 chip select, active low.
REQ-009 SHALL have port web0, input, 1, port-0 write enable, active low.
REQ-010 SHALL have port wmask0, input, WMASK_WIDTH, port-0 byte write mask; bit i enables byte i.
REQ-011 SHALL have port addr0, input, ADDR_WIDTH, port-0 address.
REQ-012 SHALL have port din0, input, DATA_WIDTH, port-0 write data.
REQ-013 SHALL have port dout0, output, DATA_WIDTH, port-0 read data (registered).
REQ-014 SHALL have port csb1, input, 1, port-1 (read-only) chip select, active low.
REQ-015 SHALL have port addr1, input, ADDR_WIDTH, port-1 address.
REQ-016 SHALL have port dout1, output, DATA_WIDTH, port-1 read data (registered).
REQ-017 SHALL have port clr_req, input, 1, a one-cycle pulse that requests a full-array clear.
REQ-018 SHALL have port busy, output, 1, high while a clear sweep is running.

Function
REQ-019 SHALL be a two-stage pipeline: edge N captures csb/web/wmask/addr/din for both ports into stage registers; edge N+1 performs the memory access and updates dout; read latency is 2 edges from request.
REQ-020 SHALL perform a port-0 read (captured csb0=0, web0=1) by loading dout0 with mem[addr0_reg]; dout0 SHALL otherwise hold its value.
REQ-021 SHALL perform a port-0 write (captured csb0=0, web0=0) on byte i of mem[addr0_reg] only where wmask0_reg[i]=1; dout0 SHALL hold during a write, never X.
REQ-022 SHALL load dout1 with mem[addr1_reg] on a port-1 read (captured csb1=0); dout1 SHALL otherwise hold.
REQ-023 SHALL give port 1 write-through forwarding when it reads the address port 0 writes in the same stage: masked bytes from din0_reg, all other bytes from the old word.
REQ-024 SHALL treat an access to an address >= RAM_DEPTH as a no-op: no write occurs and the read returns 0.
REQ-025 SHALL have a two-state FSM, IDLE and CLEAR; in IDLE, clr_req=1 moves it to CLEAR with the clear counter set to 0.
REQ-026 SHALL, in CLEAR, write 0 to mem[counter] each cycle and increment the counter; after writing RAM_DEPTH-1 it SHALL return to IDLE.
REQ-027 SHALL hold busy=1 exactly while in CLEAR; a clear takes RAM_DEPTH cycles.
REQ-028 SHALL ignore port-0 and port-1 requests captured while busy=1: no write occurs and dout0/dout1 hold.
REQ-029 SHALL ignore clr_req while already in CLEAR; the sweep does not restart.
REQ-030 SHALL let the clear take priority over any stage-2 access that lands on the same edge as the entry into CLEAR.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, set dout0=0, dout1=0, all stage csb registers to 1 (idle), and the other stage registers to 0.
REQ-032 SHALL, on reset, enter CLEAR with the counter at 0, so busy=1 on the first edge after rst deasserts and the array is zero after RAM_DEPTH cycles.
REQ-033 SHALL restart the sweep from address 0 if rst asserts during a clear.
REQ-034 SHALL NOT write the array while rst=1.

Verification
REQ-035 Bench SHALL check: reset, then wait for busy=0 (64 cycles with defaults) -> port-1 reads at addresses 0, 31 and 63 return 0.
REQ-036 Bench SHALL check: write 64'h0123456789ABCDEF to address 5 with mask 8'hFF, then read port 0 at address 5 -> dout0=64'h0123456789ABCDEF exactly 2 edges after the read request.
REQ-037 Bench SHALL check: over data 64'hFFFF..FF at address 7, write 64'h0 with mask 8'h0F -> read gives 64'hFFFFFFFF00000000.
REQ-038 Bench SHALL check: in the same cycle, write 64'hAA.. with mask 8'h01 to address 3 on port 0 and read address 3 on port 1 -> dout1 = old word with byte 0 set to 8'hAA.
REQ-039 Bench SHALL check: pulse clr_req, issue writes during busy, and assert rst mid-sweep -> busy stays high for 64 cycles after the rst, the writes are dropped, and all words read 0.
REQ-040 Bench SHALL check: with RAM_DEPTH=48, a write to address 50 -> no array change and the read returns 0.
